fetch_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 19 +
 rtl/if_id_reg.sv | 51 +++++
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: NOP encoding, PC step and fetch FSM states.
package cpu_pkg;

    // Encoding of the no-op instruction inserted for bubbles and squashes
    localparam logic [15:0] NOP = 16'h0000;

    // 16-bit instructions on a byte-addressed bus
    localparam int unsigned PC_INC = 2;

    // IDLE: no request, REQ: request outstanding,
    // HOLD: instruction parked in skid, KILL: outstanding request squashed
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > hold > load > bubble.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_hold,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc_plus2,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc_plus2,
    output logic               o_valid
);

    localparam logic [INSTR_W-1:0] NopInstr = INSTR_W'(NOP);

    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_plus2;
    logic               r_valid;

    // Register update: squash, hold, capture a delivered instruction, or insert a bubble
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_instr    <= NopInstr;
            r_pc_plus2 <= '0;
            r_valid    <= 1'b0;
        end else if (i_hold) begin
            r_instr    <= r_instr;
            r_pc_plus2 <= r_pc_plus2;
            r_valid    <= r_valid;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus2 <= i_pc_plus2;
            r_valid    <= 1'b1;
        end else begin
            r_instr    <= NopInstr;
            r_pc_plus2 <= '0;
            r_valid    <= 1'b0;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus2 = r_pc_plus2;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, one-outstanding-request imem handshake with a
// one-entry skid buffer, and the IF/ID register driven by the hazard unit.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallF,
    input  logic               stallD,
    input  logic               flushD,
    input  logic [ADDR_W-1:0]  branch_targetD,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instrD,
    output logic [ADDR_W-1:0]  pc_plus2D,
    output logic               validD,
    output logic               fetch_stallD
);

    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [ADDR_W-1:0]  r_skid_pc2;

    logic [ADDR_W-1:0]  w_pc_inc;
    logic               w_ack_live;
    logic               w_skid_full;
    logic               w_avail;
    logic [INSTR_W-1:0] w_load_instr;
    logic [ADDR_W-1:0]  w_load_pc2;

    // Wraps modulo 2^ADDR_W by truncation
    assign w_pc_inc    = r_pc + ADDR_W'(PC_INC);

    // An ack only carries usable data when the request has not been squashed
    assign w_ack_live  = (r_state == REQ) && imem_ack;
    assign w_skid_full = (r_state == HOLD);
    assign w_avail     = w_ack_live || w_skid_full;

    // Skid contents take precedence: in HOLD no request is outstanding
    assign w_load_instr = w_skid_full ? r_skid_instr : imem_rdata;
    assign w_load_pc2   = w_skid_full ? r_skid_pc2   : w_pc_inc;

    assign imem_req     = (r_state == REQ) || (r_state == KILL);
    assign imem_addr    = r_pc;
    assign fetch_stallD = !stallD && !flushD && !w_avail;

    // Fetch FSM, PC and skid buffer; flushD overrides everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_skid_instr <= '0;
            r_skid_pc2   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flushD) begin
                        r_pc <= branch_targetD;
                    end else if (!stallF) begin
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (flushD) begin
                        r_pc    <= branch_targetD;
                        r_state <= imem_ack ? IDLE : KILL;
                    end else if (imem_ack) begin
                        r_pc <= w_pc_inc;
                        if (stallD) begin
                            r_skid_instr <= imem_rdata;
                            r_skid_pc2   <= w_pc_inc;
                            r_state      <= HOLD;
                        end else begin
                            r_state <= stallF ? IDLE : REQ;
                        end
                    end
                end
                HOLD: begin
                    if (flushD) begin
                        r_pc    <= branch_targetD;
                        r_state <= IDLE;
                    end else if (!stallD) begin
                        r_state <= stallF ? IDLE : REQ;
                    end
                end
                KILL: begin
                    // Request stays open until its ack; the data is dropped
                    if (flushD) begin
                        r_pc <= branch_targetD;
                    end else if (imem_ack) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (flushD),
        .i_hold     (stallD),
        .i_load     (w_avail),
        .i_instr    (w_load_instr),
        .i_pc_plus2 (w_load_pc2),
        .o_instr    (instrD),
        .o_pc_plus2 (pc_plus2D),
        .o_valid    (validD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized hazard/memory traffic against a queue model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic [15:0] branch_targetD;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instrD;
    logic [15:0] pc_plus2D;
    logic        validD;
    logic        fetch_stallD;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallF         (stallF),
        .stallD         (stallD),
        .flushD         (flushD),
        .branch_targetD (branch_targetD),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instrD         (instrD),
        .pc_plus2D      (pc_plus2D),
        .validD         (validD),
        .fetch_stallD   (fetch_stallD)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc2;
    } ent_t;

    bit          m_known = 0;
    bit          m_out;      // a request is on the bus
    bit          m_kill;     // that request was squashed
    logic [15:0] m_pc;
    ent_t        m_skid[$];
    logic [15:0] m_if_instr;
    logic [15:0] m_if_pc2;
    bit          m_if_valid;

    task automatic model_step();
        ent_t e;
        bit   dlv;
        dlv = 0;
        if (rst) begin
            m_known    = 1;
            m_out      = 0;
            m_kill     = 0;
            m_pc       = 16'h0000;
            m_skid.delete();
            m_if_instr = 16'h0000;
            m_if_pc2   = 16'h0000;
            m_if_valid = 0;
        end else if (m_known) begin
            if (flushD) begin
                if (m_out && !m_kill) begin
                    if (imem_ack) m_out = 0;
                    else m_kill = 1;
                end
                m_skid.delete();
                m_pc       = branch_targetD;
                m_if_instr = 16'h0000;
                m_if_pc2   = 16'h0000;
                m_if_valid = 0;
            end else begin
                if (m_out && m_kill) begin
                    if (imem_ack) begin
                        m_out  = 0;
                        m_kill = 0;
                    end
                end else if (m_out) begin
                    if (imem_ack) begin
                        e.instr = imem_rdata;
                        e.pc2   = m_pc + 16'd2;
                        m_pc    = m_pc + 16'd2;
                        m_out   = 0;
                        if (stallD) m_skid.push_back(e);
                        else begin
                            dlv   = 1;
                            m_out = !stallF;
                        end
                    end
                end else if (m_skid.size() != 0) begin
                    if (!stallD) begin
                        e     = m_skid.pop_front();
                        dlv   = 1;
                        m_out = !stallF;
                    end
                end else if (!stallF) begin
                    m_out = 1;
                end
                if (!stallD) begin
                    if (dlv) begin
                        m_if_instr = e.instr;
                        m_if_pc2   = e.pc2;
                        m_if_valid = 1;
                    end else begin
                        m_if_instr = 16'h0000;
                        m_if_pc2   = 16'h0000;
                        m_if_valid = 0;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model, away from the active edge
    initial forever begin
        bit avail;
        @(negedge clk);
        if (m_known) begin
            avail = (m_out && !m_kill && imem_ack) || (m_skid.size() != 0);
            chk("imem_req", 32'(imem_req), 32'(m_out));
            chk("imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("validD", 32'(validD), 32'(m_if_valid));
            chk("instrD", 32'(instrD), 32'(m_if_instr));
            if (m_if_valid) chk("pc_plus2D", 32'(pc_plus2D), 32'(m_if_pc2));
            chk("fetch_stallD", 32'(fetch_stallD), 32'(!stallD && !flushD && !avail));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic [15:0] tgt, input logic a, input logic [15:0] rd);
        @(posedge clk);
        #1;
        rst            = r;
        stallF         = sf;
        stallD         = sd;
        flushD         = fd;
        branch_targetD = tgt;
        imem_ack       = a;
        imem_rdata     = rd;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [15:0] tgts [4];
        tgts[0] = 16'hFFFC;
        tgts[1] = 16'hFFFE;
        tgts[2] = 16'h0040;
        tgts[3] = 16'h0000;
        rst = 1; stallF = 0; stallD = 0; flushD = 0;
        branch_targetD = 0; imem_ack = 0; imem_rdata = 0;

        // Reset state
        cyc(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", 32'(imem_addr), 'h0000);
        chk("rst_valid", 32'(validD), 0);
        chk("rst_instr", 32'(instrD), 'h0000);
        chk("rst_pc2", 32'(pc_plus2D), 'h0000);
        chk("rst_fstall", 32'(fetch_stallD), 1);

        // Sequential fetch, 1-cycle ack
        cyc(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("seq_req0", 32'(imem_req), 1);
        chk("seq_addr0", 32'(imem_addr), 'h0000);
        cyc(0, 0, 0, 0, 16'h0000, 1, 16'h1111);
        chk("seq_fstall_ack", 32'(fetch_stallD), 0);
        cyc(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("seq_instr0", 32'(instrD), 'h1111);
        chk("seq_pc2_0", 32'(pc_plus2D), 'h0002);
        chk("seq_valid0", 32'(validD), 1);
        chk("seq_addr1", 32'(imem_addr), 'h0002);
        cyc(0, 0, 0, 0, 16'h0000, 1, 16'h2222);
        cyc(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("seq_instr1", 32'(instrD), 'h2222);
        chk("seq_pc2_1", 32'(pc_plus2D), 'h0004);
        chk("seq_addr2", 32'(imem_addr), 'h0004);

        // Ack under stallD for 3 cycles: parked in skid, no new request
        cyc(0, 0, 1, 0, 16'h0000, 1, 16'hA123);
        chk("stall_bubble", 32'(validD), 0);
        cyc(0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        chk("stall_noreq", 32'(imem_req), 0);
        chk("stall_addr", 32'(imem_addr), 'h0006);
        cyc(0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("skid_fstall", 32'(fetch_stallD), 0);
        cyc(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("skid_instr", 32'(instrD), 'hA123);
        chk("skid_valid", 32'(validD), 1);
        chk("skid_pc2", 32'(pc_plus2D), 'h0006);
        chk("skid_nextreq", 32'(imem_req), 1);
        chk("skid_nextaddr", 32'(imem_addr), 'h0006);

        // Flush with request outstanding at 0008
        cyc(0, 0, 0, 0, 16'h0000, 1, 16'h3333);
        cyc(0, 0, 0, 1, 16'h0040, 0, 16'h0000);
        chk("kill_pre_addr", 32'(imem_addr), 'h0008);
        chk("kill_pre_instr", 32'(instrD), 'h3333);
        cyc(0, 0, 0, 0, 16'h0000, 1, 16'hBEEF);
        chk("kill_req", 32'(imem_req), 1);
        chk("kill_valid", 32'(validD), 0);
        chk("kill_addr", 32'(imem_addr), 'h0040);
        cyc(0, 0, 0, 0, 16'h0000, 1, 16'hDEAD);
        chk("kill_drop_valid", 32'(validD), 0);
        chk("kill_drop_instr", 32'(instrD), 'h0000);
        chk("kill_idle_req", 32'(imem_req), 0);
        cyc(0, 0, 0, 0, 16'h0000, 1, 16'h4444);
        chk("redir_req", 32'(imem_req), 1);
        chk("redir_addr", 32'(imem_addr), 'h0040);

        // flushD together with stallD while an instruction sits in the skid
        cyc(0, 0, 1, 0, 16'h0000, 1, 16'h5555);
        chk("fs_pre_instr", 32'(instrD), 'h4444);
        chk("fs_pre_pc2", 32'(pc_plus2D), 'h0042);
        cyc(0, 0, 1, 1, 16'h0040, 0, 16'h0000);
        chk("fs_hold_instr", 32'(instrD), 'h4444);
        cyc(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("fs_valid", 32'(validD), 0);
        chk("fs_instr", 32'(instrD), 'h0000);
        chk("fs_addr", 32'(imem_addr), 'h0040);
        cyc(0, 0, 0, 0, 16'h0000, 1, 16'h6666);
        chk("fs_refetch", 32'(imem_addr), 'h0040);
        cyc(0, 0, 0, 1, 16'hFFFE, 0, 16'h0000);
        chk("fs_new_instr", 32'(instrD), 'h6666);

        // PC wrap at FFFE
        cyc(0, 0, 0, 0, 16'h0000, 1, 16'h0000);
        chk("wrap_addr_kill", 32'(imem_addr), 'hFFFE);
        cyc(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 0, 0, 0, 16'h0000, 1, 16'h7777);
        chk("wrap_addr", 32'(imem_addr), 'hFFFE);

        // Reset while a request is outstanding, ack the next cycle
        cyc(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("wrap_instr", 32'(instrD), 'h7777);
        chk("wrap_pc2", 32'(pc_plus2D), 'h0000);
        chk("wrap_next", 32'(imem_addr), 'h0000);
        chk("model_wrap_pc2", 32'(m_if_pc2), 'h0000);
        cyc(0, 0, 0, 0, 16'h0000, 1, 16'h9999);
        chk("rstreq_req", 32'(imem_req), 0);
        chk("rstreq_valid", 32'(validD), 0);
        cyc(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("rstreq_valid2", 32'(validD), 0);
        chk("rstreq_addr", 32'(imem_addr), 'h0000);
        chk("rstreq_req2", 32'(imem_req), 1);

        // Randomized traffic; memory answers the model's request after 0-3 cycles
        lat = 1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst    = ($urandom_range(0, 199) == 0);
            stallF = ($urandom_range(0, 4) == 0);
            stallD = ($urandom_range(0, 3) == 0);
            flushD = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) branch_targetD = tgts[$urandom_range(0, 3)];
            else branch_targetD = 16'($urandom) & 16'hFFFE;
            imem_rdata = 16'($urandom);
            if (m_out) begin
                if (lat == 0) begin
                    imem_ack = 1;
                    lat = $urandom_range(0, 3);
                end else begin
                    imem_ack = 0;
                    lat--;
                end
            end else begin
                // Stray ack while idle must be ignored
                imem_ack = (m_skid.size() == 0) && ($urandom_range(0, 7) == 0);
            end
        end
        @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
